// File: rtl/semaforo_pkg.sv
// Shared lamp encodings, FSM state type and small elaboration-time helpers
// for the traffic-light phase scheduler.
package semaforo_pkg;

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bit width able to hold values 0..v-1, never narrower than one bit.
    function automatic int width_for(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/semaforo_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first pending phase after the last granted
// one, wrapping modulo NUM_PHASES.
module rr_arbiter #(
    parameter  int NUM_PHASES = 4,
    localparam int AW         = $clog2(NUM_PHASES)
) (
    input  logic [NUM_PHASES-1:0] i_pending,
    input  logic [AW-1:0]         i_last,
    output logic                  o_valid,
    output logic [AW-1:0]         o_winner
);

    logic [AW:0]           w_sum  [NUM_PHASES];
    logic [AW-1:0]         w_cand [NUM_PHASES];
    logic [NUM_PHASES-1:0] w_hit;

    // Candidate gi is the phase (gi+1) steps after the last grant.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, i_last} + (AW+1)'(gi + 1);
            assign w_cand[gi] = (w_sum[gi] >= (AW+1)'(NUM_PHASES))
                              ? AW'(w_sum[gi] - (AW+1)'(NUM_PHASES))
                              : w_sum[gi][AW-1:0];
            assign w_hit[gi]  = i_pending[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_valid  = |w_hit;
        o_winner = i_last;
        for (int k = NUM_PHASES - 1; k >= 0; k--) begin
            if (w_hit[k]) o_winner = w_cand[k];
        end
    end

endmodule

// File: rtl/semaforo_scheduler.sv
// Traffic-light scheduler: one phase green at a time, round-robin service of
// latched requests with min/max green, yellow and all-red clearance intervals.
module semaforo_scheduler
    import semaforo_pkg::*;
#(
    parameter  int NUM_PHASES  = 4,
    parameter  int MIN_GREEN   = 4,
    parameter  int MAX_GREEN   = 10,
    parameter  int YELLOW_TIME = 2,
    parameter  int ALLRED_TIME = 1,
    localparam int AW          = $clog2(NUM_PHASES)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_PHASES-1:0]   i_req,
    output logic [2*NUM_PHASES-1:0] o_light,
    output logic [NUM_PHASES-1:0]   o_grant,
    output logic [AW-1:0]           o_active_phase,
    output logic                    o_phase_start
);

    localparam int TMAX = max3(MAX_GREEN - 1, YELLOW_TIME - 1, ALLRED_TIME - 1);
    localparam int TW   = width_for(TMAX + 1);

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [NUM_PHASES-1:0] r_pending;
    logic [AW-1:0]         r_active;
    logic                  r_phase_start;

    state_t                w_state_next;
    logic [TW-1:0]         w_timer_next;
    logic [NUM_PHASES-1:0] w_pending_next;
    logic [AW-1:0]         w_active_next;
    logic                  w_start_next;

    logic                  w_valid;
    logic [AW-1:0]         w_winner;
    logic [NUM_PHASES-1:0] w_active_onehot;
    logic [NUM_PHASES-1:0] w_winner_onehot;
    logic [NUM_PHASES-1:0] w_green_mask;
    logic                  w_other_pending;
    int                    w_tval;

    rr_arbiter #(
        .NUM_PHASES (NUM_PHASES)
    ) u_rr_arbiter (
        .i_pending (r_pending),
        .i_last    (r_active),
        .o_valid   (w_valid),
        .o_winner  (w_winner)
    );

    assign w_tval = int'(r_timer);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_ALL_RED;
            r_timer       <= '0;
            r_pending     <= '0;
            r_active      <= AW'(NUM_PHASES - 1);
            r_phase_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timer       <= w_timer_next;
            r_pending     <= w_pending_next;
            r_active      <= w_active_next;
            r_phase_start <= w_start_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_active_next   = r_active;
        w_start_next    = 1'b0;
        w_active_onehot = '0;
        w_active_onehot[r_active] = 1'b1;
        w_winner_onehot = '0;
        w_green_mask    = (r_state == ST_GREEN) ? w_active_onehot : '0;
        w_other_pending = |(r_pending & ~w_active_onehot);

        case (r_state)
            ST_ALL_RED: begin
                if (w_tval >= ALLRED_TIME - 1 && w_valid) begin
                    w_state_next  = ST_GREEN;
                    w_active_next = w_winner;
                    w_start_next  = 1'b1;
                    w_winner_onehot[w_winner] = 1'b1;
                end
            end
            ST_GREEN: begin
                // Only yield when someone else waits; own demand extends up to MAX_GREEN.
                if (w_tval >= MIN_GREEN - 1 && w_other_pending &&
                    (!i_req[r_active] || w_tval >= MAX_GREEN - 1)) begin
                    w_state_next = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (w_tval >= YELLOW_TIME - 1) w_state_next = ST_ALL_RED;
            end
            default: w_state_next = ST_ALL_RED;
        endcase

        if (w_state_next != r_state) begin
            w_timer_next = '0;
        end else if (w_tval < TMAX) begin
            w_timer_next = r_timer + 1'b1;
        end else begin
            w_timer_next = r_timer;
        end

        // Clearing on green entry takes priority over a same-cycle request.
        w_pending_next = (r_pending | (i_req & ~w_green_mask)) & ~w_winner_onehot;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_lamp
            logic w_lit;
            assign w_lit = (r_state != ST_ALL_RED) && (r_active == AW'(gi));
            assign o_grant[gi] = w_lit;
            assign o_light[2*gi +: 2] = !w_lit ? LAMP_RED :
                                        (r_state == ST_GREEN) ? LAMP_GREEN : LAMP_YELLOW;
        end
    endgenerate

    assign o_active_phase = r_active;
    assign o_phase_start  = r_phase_start;

endmodule

// File: tb/tb_semaforo_scheduler.sv
// Self-checking bench for semaforo_scheduler: directed scenarios plus a long
// randomized run compared cycle by cycle against a behavioural model.
module tb_semaforo_scheduler;

    localparam int N     = 4;
    localparam int MIN_G = 4;
    localparam int MAX_G = 10;
    localparam int YEL   = 2;
    localparam int ARED  = 1;
    localparam int AW    = $clog2(N);
    localparam logic [2*N-1:0] ALL_RED_L = 8'b10101010;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] light;
    logic [N-1:0]   grant;
    logic [AW-1:0]  active;
    logic           start;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    semaforo_scheduler #(
        .NUM_PHASES  (N),
        .MIN_GREEN   (MIN_G),
        .MAX_GREEN   (MAX_G),
        .YELLOW_TIME (YEL),
        .ALLRED_TIME (ARED)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req          (req),
        .o_light        (light),
        .o_grant        (grant),
        .o_active_phase (active),
        .o_phase_start  (start)
    );

    // Behavioural model: mode 0 = all red, 1 = green, 2 = yellow.
    int           m_mode;
    int           m_cnt;
    int           m_last;
    logic [N-1:0] m_pend;
    logic         m_start;

    function automatic void model_reset();
        m_mode  = 0;
        m_cnt   = 0;
        m_last  = N - 1;
        m_pend  = '0;
        m_start = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r);
        int           nmode = m_mode;
        int           nlast = m_last;
        logic         nstart = 1'b0;
        logic [N-1:0] np = m_pend;
        bit           others = 0;
        for (int i = 0; i < N; i++)
            if (r[i] && !(m_mode == 1 && m_last == i)) np[i] = 1'b1;
        if (m_mode == 0) begin
            if (m_cnt >= ARED - 1) begin
                for (int k = 1; k <= N; k++) begin
                    int p = (m_last + k) % N;
                    if (!nstart && m_pend[p]) begin
                        nstart = 1'b1;
                        nmode  = 1;
                        nlast  = p;
                    end
                end
            end
        end else if (m_mode == 1) begin
            for (int i = 0; i < N; i++)
                if (i != m_last && m_pend[i]) others = 1;
            if (m_cnt >= MIN_G - 1 && others && (!r[m_last] || m_cnt >= MAX_G - 1))
                nmode = 2;
        end else begin
            if (m_cnt >= YEL - 1) nmode = 0;
        end
        if (nstart) np[nlast] = 1'b0;
        m_cnt   = (nmode != m_mode) ? 0 : m_cnt + 1;
        m_mode  = nmode;
        m_last  = nlast;
        m_pend  = np;
        m_start = nstart;
    endfunction

    function automatic logic [2*N-1:0] exp_light();
        logic [2*N-1:0] v;
        for (int i = 0; i < N; i++)
            v[2*i +: 2] = (m_mode != 0 && m_last == i) ? ((m_mode == 1) ? 2'b00 : 2'b01) : 2'b10;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] v = '0;
        if (m_mode != 0) v[m_last] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of requests, advance the model, land on the next negedge.
    task automatic tick(input logic [N-1:0] r);
        req = r;
        model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (light !== ALL_RED_L) begin n_fail++; $display("FAIL reset_light got %b want %b", light, ALL_RED_L); end
        n_checks++;
        if (grant !== '0) begin n_fail++; $display("FAIL reset_grant got %b want 0", grant); end
        n_checks++;
        if (active !== AW'(N - 1)) begin n_fail++; $display("FAIL reset_active got %0d want %0d", active, N - 1); end
        n_checks++;
        if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", start); end
        req   = '0;
        rst_n = 1'b1;
        repeat (5) tick('0);
        n_checks++;
        if (grant !== '0) begin n_fail++; $display("FAIL reset_no_latch got grant %b want 0", grant); end
        $display("test_reset done");
    endtask

    task automatic test_idle();
        int bad = 0;
        do_reset(1);
        for (int c = 0; c < 50; c++) begin
            tick('0);
            n_checks++;
            if (light !== ALL_RED_L || grant !== '0 || start !== 1'b0) begin
                n_fail++;
                bad++;
                $display("FAIL idle cycle %0d got light %b grant %b start %b want %b 0 0", c, light, grant, start, ALL_RED_L);
            end
        end
        $display("test_idle done, %0d bad cycles", bad);
    endtask

    task automatic test_single_request();
        int waited = 0;
        int pulses = 0;
        tick(4'b0100);
        while (grant !== 4'b0100 && waited < 10) begin tick('0); waited++; end
        n_checks++;
        if (waited != 1) begin n_fail++; $display("FAIL single_latency got %0d want 1", waited); end
        n_checks++;
        if (light !== 8'b10001010) begin n_fail++; $display("FAIL single_light got %b want 10001010", light); end
        n_checks++;
        if (active !== 2'd2 || start !== 1'b1) begin
            n_fail++; $display("FAIL single_start got active %0d start %b want 2 1", active, start);
        end
        for (int c = 0; c < 100; c++) begin
            tick('0);
            if (start) pulses++;
            n_checks++;
            if (light !== 8'b10001010 || grant !== 4'b0100) begin
                n_fail++; $display("FAIL single_hold cycle %0d got light %b grant %b want 10001010 0100", c, light, grant);
            end
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL single_extra_pulses got %0d want 0", pulses); end
        $display("test_single_request done, latency %0d", waited);
    endtask

    task automatic test_max_green();
        int w = 0, g = 1, y = 0, r = 0, guard = 0;
        do_reset(1);
        tick(4'b0001);
        while (grant !== 4'b0001 && w < 10) begin tick(4'b0001); w++; end
        tick(4'b0011);
        while (light[1:0] === 2'b00 && guard < 50) begin g++; tick(4'b0011); guard++; end
        while (light[1:0] === 2'b01 && guard < 50) begin y++; tick(4'b0011); guard++; end
        while (light === ALL_RED_L && guard < 50) begin r++; tick(4'b0011); guard++; end
        n_checks++;
        if (g != MAX_G) begin n_fail++; $display("FAIL max_green_len got %0d want %0d", g, MAX_G); end
        n_checks++;
        if (y != YEL) begin n_fail++; $display("FAIL max_yellow_len got %0d want %0d", y, YEL); end
        n_checks++;
        if (r != ARED) begin n_fail++; $display("FAIL max_allred_len got %0d want %0d", r, ARED); end
        n_checks++;
        if (grant !== 4'b0010 || light !== 8'b10100010) begin
            n_fail++; $display("FAIL max_next_phase got grant %b light %b want 0010 10100010", grant, light);
        end
        $display("test_max_green done, green %0d yellow %0d allred %0d", g, y, r);
    endtask

    task automatic test_min_green();
        int w = 0, g = 1, guard = 0;
        do_reset(1);
        tick(4'b1001);
        while (grant !== 4'b0001 && w < 10) begin tick(4'b1001); w++; end
        tick(4'b1001);
        while (light[1:0] === 2'b00 && guard < 50) begin g++; tick(4'b1000); guard++; end
        n_checks++;
        if (g != MIN_G) begin n_fail++; $display("FAIL min_green_len got %0d want %0d", g, MIN_G); end
        n_checks++;
        if (light[1:0] !== 2'b01) begin n_fail++; $display("FAIL min_then_yellow got %b want 01", light[1:0]); end
        $display("test_min_green done, green %0d", g);
    endtask

    task automatic test_round_robin();
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int got = 0, guard = 0;
        do_reset(1);
        while (got < 5 && guard < 300) begin
            tick(4'b1111);
            guard++;
            if (start) begin order[got] = int'(active); got++; end
        end
        n_checks++;
        if (got != 5) begin n_fail++; $display("FAIL rr_timeout got %0d grants want 5", got); end
        for (int i = 0; i < got; i++) begin
            n_checks++;
            if (order[i] != exp_order[i]) begin
                n_fail++; $display("FAIL rr_order grant %0d got phase %0d want %0d", i, order[i], exp_order[i]);
            end
        end
        $display("test_round_robin done, %0d grants", got);
    endtask

    task automatic test_reset_midyellow();
        int w = 0;
        do_reset(1);
        tick(4'b1001);
        while (light[1:0] !== 2'b01 && w < 40) begin tick(4'b1000); w++; end
        n_checks++;
        if (light[1:0] !== 2'b01) begin n_fail++; $display("FAIL midyel_reach got %b want 01", light[1:0]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (light !== ALL_RED_L || grant !== '0) begin
            n_fail++; $display("FAIL midyel_async got light %b grant %b want %b 0", light, grant, ALL_RED_L);
        end
        req = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick('0);
            n_checks++;
            if (grant !== '0 || light !== ALL_RED_L) begin
                n_fail++; $display("FAIL midyel_idle cycle %0d got grant %b light %b want 0 %b", c, grant, light, ALL_RED_L);
            end
        end
        $display("test_reset_midyellow done");
    endtask

    task automatic test_random();
        logic [N-1:0] r_cur = '0;
        int  prev_mode = 0, run = 0, bad = 0;
        bit  prev_other = 0;
        int  since [N];
        do_reset(1);
        for (int i = 0; i < N; i++) since[i] = -1;
        for (int c = 0; c < 10000; c++) begin
            int mode = 0, lit = 0;
            bool_blk: begin end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) r_cur[i] = ~r_cur[i];
            prev_other = (m_mode == 1) && ((m_pend & ~(N'(1) << m_last)) != '0);
            tick(r_cur);

            n_checks++;
            if ({light, grant, active, start} !== {exp_light(), exp_grant(), AW'(m_last), m_start}) begin
                n_fail++; bad++;
                $display("FAIL rand_model cycle %0d got %b %b %0d %b want %b %b %0d %b",
                         c, light, grant, active, start, exp_light(), exp_grant(), m_last, m_start);
            end

            for (int i = 0; i < N; i++) begin
                if (light[2*i +: 2] !== 2'b10) lit++;
                if (light[2*i +: 2] === 2'b00) mode = 1;
                if (light[2*i +: 2] === 2'b01) mode = 2;
            end
            n_checks++;
            if (lit > 1) begin n_fail++; bad++; $display("FAIL rand_one_lamp cycle %0d got %0d lit want <=1", c, lit); end

            if (mode == prev_mode) begin
                run++;
            end else begin
                n_checks++;
                if ((prev_mode == 1 && run < MIN_G) || (prev_mode == 2 && run != YEL) ||
                    (prev_mode == 0 && run < ARED)) begin
                    n_fail++; bad++;
                    $display("FAIL rand_duration cycle %0d mode %0d got %0d cycles", c, prev_mode, run);
                end
                run = 1;
            end
            if (mode == 1 && run > MAX_G) begin
                n_checks++;
                if (prev_other) begin
                    n_fail++; bad++;
                    $display("FAIL rand_max_green cycle %0d got %0d cycles want <=%0d while contended", c, run, MAX_G);
                end
            end
            prev_mode = mode;

            if (start) begin
                for (int i = 0; i < N; i++) begin
                    if (i == int'(active)) since[i] = -1;
                    else if (since[i] >= 0) begin
                        since[i]++;
                        n_checks++;
                        if (since[i] >= N) begin
                            n_fail++; bad++;
                            $display("FAIL rand_fairness cycle %0d phase %0d waited %0d grants want <%0d", c, i, since[i], N);
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++)
                if (m_pend[i] && since[i] < 0) since[i] = 0;
        end
        $display("test_random done, %0d bad observations", bad);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_single_request();
        test_max_green();
        test_min_green();
        test_round_robin();
        test_reset_midyellow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
